// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router constants and types. The round-robin arbiter
//                and the router datapath both import this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int unsigned c_data_width = 8;
    localparam int unsigned c_num_ports  = 4;

    // Index of one of the four router ports
    typedef logic [1:0] port_idx_t;

    // Round-robin successor of a port index; 3 wraps to 0
    function automatic port_idx_t next_idx(input port_idx_t idx);
        return idx + port_idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_rr_arbiter_if
//  Description : Input and output beat bundles of the 4x4 round-robin router
//                arbiter. master = traffic source/sink, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_rr_arbiter_if
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_data_width
) ();

    logic [3:0][DATA_WIDTH-1:0] in_data;
    port_idx_t [3:0]            in_dest;
    logic [3:0]                 in_valid;
    logic [3:0]                 in_ready;
    logic [3:0][DATA_WIDTH-1:0] out_data;
    port_idx_t [3:0]            out_src;
    logic [3:0]                 out_valid;
    logic [3:0]                 out_ready;

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/router_rr_arbiter_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4
//  Description : Combinational 4-way round-robin arbiter. It grants the first
//                requester found when searching from i_ptr upward, modulo 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4
    import router_pkg::*;
(
    input  wire logic [3:0] i_req,
    input  wire port_idx_t  i_ptr,
    output logic [3:0]      o_grant,
    output port_idx_t       o_grant_idx,
    output logic            o_grant_valid
);

    port_idx_t w_idx;

    // Scan from farthest to nearest offset so the requester closest to i_ptr wins
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + port_idx_t'(k);
            if (i_req[w_idx]) begin
                o_grant       = 4'b0001 << w_idx;
                o_grant_idx   = w_idx;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : router_rr_arbiter
//  Description : 4x4 router crossbar. Each output has its own round-robin
//                arbiter and a one-deep output register. Grants go only to
//                outputs whose register is empty or is draining this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_rr_arbiter
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_data_width,
    parameter int unsigned NUM_PORTS  = c_num_ports
) (
    input  wire logic           clk,
    input  wire logic           rst,
    router_rr_arbiter_if.slave  bus
);

    logic [3:0][3:0]            w_arb_req;
    logic [3:0][3:0]            w_grant;
    port_idx_t [3:0]            w_grant_idx;
    logic [3:0]                 w_grant_valid;
    logic [3:0]                 w_can_accept;
    logic [3:0]                 w_in_ready;

    port_idx_t [3:0]            r_ptr;
    logic [3:0][DATA_WIDTH-1:0] r_out_data;
    port_idx_t [3:0]            r_out_src;
    logic [3:0]                 r_out_valid;

    // Per-output requests. They are masked while the output is stalled or in reset.
    always_comb begin
        w_arb_req    = '0;
        w_can_accept = '0;
        for (int o = 0; o < 4; o++) begin
            w_can_accept[o] = !r_out_valid[o] || bus.out_ready[o];
            for (int i = 0; i < 4; i++) begin
                w_arb_req[o][i] = bus.in_valid[i] && (bus.in_dest[i] == port_idx_t'(o))
                                  && w_can_accept[o] && !rst;
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arb4 u_arb (
            .i_req         (w_arb_req[o]),
            .i_ptr         (r_ptr[o]),
            .o_grant       (w_grant[o]),
            .o_grant_idx   (w_grant_idx[o]),
            .o_grant_valid (w_grant_valid[o])
        );
    end

    // An input requests one output at most, so OR-ing the grants yields at most one grant per input
    always_comb begin
        w_in_ready = '0;
        for (int o = 0; o < 4; o++) begin
            w_in_ready = w_in_ready | w_grant[o];
        end
    end

    // Output registers and round-robin pointers: a grant loads, a drain without a grant clears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= '0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (w_grant_valid[o]) begin
                    r_out_data[o]  <= bus.in_data[w_grant_idx[o]];
                    r_out_src[o]   <= w_grant_idx[o];
                    r_out_valid[o] <= 1'b1;
                    r_ptr[o]       <= next_idx(w_grant_idx[o]);
                end else if (bus.out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_router_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_rr_arbiter
//  Description : Directed self-checking bench for router_rr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_rr_arbiter;
    import router_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    router_rr_arbiter_if #(.DATA_WIDTH(8)) bus ();

    router_rr_arbiter #(.DATA_WIDTH(8), .NUM_PORTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.in_data   = {8'h04, 8'h03, 8'h02, 8'h01};
        bus.in_dest   = {2'd0, 2'd0, 2'd0, 2'd0};
        bus.in_valid  = 4'hF;
        bus.out_ready = 4'hF;

        // Reset held for 2 cycles with traffic offered
        step();
        #1 chk("rst_in_ready_c1", 32'(bus.in_ready), 32'h0);
        step();
        #1 chk("rst_in_ready_c2", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_src", 32'(bus.out_src), 32'h0);
        rst = 1'b0;
        bus.in_valid = 4'h0;
        step();
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

        // Four inputs to four distinct outputs in parallel
        bus.in_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus.in_dest  = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.in_valid = 4'hF;
        #1 chk("par_in_ready", 32'(bus.in_ready), 32'hF);
        step();
        chk("par_out_data", bus.out_data, 32'hD4C3B2A1);
        chk("par_out_src", 32'(bus.out_src), 32'hE4);
        chk("par_out_valid", 32'(bus.out_valid), 32'hF);
        bus.in_valid = 4'h0;
        step();
        chk("par_drain", 32'(bus.out_valid), 32'h0);

        // Reset again so every pointer returns to 0
        rst = 1'b1;
        step();
        rst = 1'b0;

        // All four inputs to output 2: serviced 0,1,2,3 back to back
        bus.in_data  = {8'h77, 8'h33, 8'hAA, 8'h55};
        bus.in_dest  = {2'd2, 2'd2, 2'd2, 2'd2};
        bus.in_valid = 4'hF;
        #1 chk("rr_in_ready_0", 32'(bus.in_ready), 32'h1);
        step();
        chk("rr_data_0", 32'(bus.out_data[2]), 32'h55);
        chk("rr_src_0", 32'(bus.out_src[2]), 32'd0);
        bus.in_valid = 4'hE;
        #1 chk("rr_in_ready_1", 32'(bus.in_ready), 32'h2);
        step();
        chk("rr_data_1", 32'(bus.out_data[2]), 32'hAA);
        chk("rr_src_1", 32'(bus.out_src[2]), 32'd1);
        bus.in_valid = 4'hC;
        #1 chk("rr_in_ready_2", 32'(bus.in_ready), 32'h4);
        step();
        chk("rr_data_2", 32'(bus.out_data[2]), 32'h33);
        bus.in_valid = 4'h8;
        #1 chk("rr_in_ready_3", 32'(bus.in_ready), 32'h8);
        step();
        chk("rr_data_3", 32'(bus.out_data[2]), 32'h77);
        chk("rr_src_3", 32'(bus.out_src[2]), 32'd3);
        chk("rr_valid_3", 32'(bus.out_valid), 32'h4);
        // Pointer of output 2 wrapped to 0: input 0 beats input 1
        bus.in_valid = 4'h3;
        #1 chk("rr_ptr_wrap", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 4'h0;
        step();
        chk("rr_drain", 32'(bus.out_valid), 32'h0);

        // Backpressure on output 1 holding B2
        bus.in_data  = {8'h3C, 8'h00, 8'hB2, 8'h00};
        bus.in_dest  = {2'd1, 2'd0, 2'd1, 2'd0};
        bus.in_valid = 4'h2;
        step();
        bus.in_valid  = 4'h8;
        bus.out_ready = 4'hD;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
            step();
            chk("stall_data", 32'(bus.out_data[1]), 32'hB2);
            chk("stall_valid", 32'(bus.out_valid[1]), 32'h1);
        end
        bus.out_ready = 4'hF;
        #1 chk("unstall_in_ready", 32'(bus.in_ready), 32'h8);
        step();
        chk("unstall_data", 32'(bus.out_data[1]), 32'h3C);
        chk("unstall_src", 32'(bus.out_src[1]), 32'd3);
        bus.in_valid = 4'h0;
        step();

        // Move pointer of output 0 to 2 with a grant to input 1
        bus.in_data  = {8'h43, 8'h00, 8'h11, 8'h00};
        bus.in_dest  = {2'd0, 2'd0, 2'd0, 2'd0};
        bus.in_valid = 4'h2;
        step();
        bus.in_valid = 4'h0;
        step();
        // Inputs 1 and 3 compete: 3 wins first, then pointer wraps and 1 follows
        bus.in_data  = {8'h43, 8'h00, 8'h21, 8'h00};
        bus.in_valid = 4'hA;
        #1 chk("wrap_in_ready_a", 32'(bus.in_ready), 32'h8);
        step();
        chk("wrap_data_a", 32'(bus.out_data[0]), 32'h43);
        chk("wrap_src_a", 32'(bus.out_src[0]), 32'd3);
        bus.in_valid = 4'h2;
        #1 chk("wrap_in_ready_b", 32'(bus.in_ready), 32'h2);
        step();
        chk("wrap_data_b", 32'(bus.out_data[0]), 32'h21);
        chk("wrap_src_b", 32'(bus.out_src[0]), 32'd1);
        bus.in_valid = 4'h0;

        // Reset while output 0 holds a stalled beat
        bus.out_ready = 4'hE;
        step();
        chk("hold_valid", 32'(bus.out_valid[0]), 32'h1);
        rst          = 1'b1;
        bus.in_valid = 4'h1;
        #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_data", bus.out_data, 32'h0);
        rst           = 1'b0;
        bus.in_valid  = 4'h0;
        bus.out_ready = 4'hF;
        step();
        chk("no_replay_1", 32'(bus.out_valid), 32'h0);
        step();
        chk("no_replay_2", 32'(bus.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
